// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit
// Define CTRL_STACK_CHECK_EN to trap return-stack overflow/underflow into FAULT.
module multicycle_controller #(
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ack,
  input  logic               alu_c,
  input  logic               alu_z,
  input  logic               shift_c,
  input  logic               shift_z,
  output logic               mem_req,
  output logic               mem_write,
  output logic               mem_addr_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_mux,
  output logic               reg_write,
  output logic [1:0]         reg_write_mux,
  output logic               alu_in_mux,
  output logic               reg_B_mux,
  output logic               alu_use_carry,
  output logic [2:0]         alu_op,
  output logic               push,
  output logic               pop,
  output logic               flag_c,
  output logic               flag_z,
  output logic               halted,
  output logic               stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [SP_W-1:0]    r_sp;
  logic               r_c;
  logic               r_z;

  logic [4:0]      w_op;
  logic            w_is_arith;
  logic            w_is_mem;
  logic            w_is_branch;
  logic            w_is_shift;
  logic            w_is_jsb;
  logic            w_is_ret;
  logic            w_is_halt;
  logic            w_flag;
  logic            w_taken;
  logic            w_stack_fault;
  logic [SP_W-1:0] w_sp_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic            w_unused_bits;

  assign w_op        = r_ir[INSTR_W-1 -: 5];
  assign w_is_arith  = ~w_op[4];
  assign w_is_mem    = (w_op[4:2] == 3'b100);
  assign w_is_branch = (w_op[4:2] == 3'b101);
  assign w_is_shift  = (w_op[4:2] == 3'b110);
  assign w_is_jsb    = (w_op == 5'b11101);
  assign w_is_ret    = (w_op == 5'b11110);
  assign w_is_halt   = (w_op == 5'b11111);
  assign w_flag      = w_op[1] ? r_c : r_z;
  assign w_taken     = w_op[0] ? ~w_flag : w_flag;

`ifdef CTRL_STACK_CHECK_EN
  assign w_sp_inc      = r_sp + SP_W'(1);
  assign w_sp_dec      = r_sp - SP_W'(1);
  assign w_stack_fault = (w_is_jsb && (r_sp == SP_W'(STACK_DEPTH))) ||
                         (w_is_ret && (r_sp == '0));
`else
  // Unchecked stack: the pointer stays inside 0..STACK_DEPTH-1 and wraps.
  assign w_sp_inc      = {1'b0, r_sp[SP_W-2:0] + (SP_W-1)'(1)};
  assign w_sp_dec      = {1'b0, r_sp[SP_W-2:0] - (SP_W-1)'(1)};
  assign w_stack_fault = 1'b0;
`endif

  assign w_unused_bits = ^{r_ir[INSTR_W-6:0], r_sp};
  assign flag_c        = r_c;
  assign flag_z        = r_z;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= '0;
      r_sp <= '0;
      r_c  <= 1'b0;
      r_z  <= 1'b0;
    end else begin
      if (ir_write) r_ir <= instr_in;
      if (r_state == S_EXEC) begin
        if (w_is_arith) begin
          r_c <= alu_c;
          r_z <= alu_z;
        end else if (w_is_shift) begin
          r_c <= shift_c;
          r_z <= shift_z;
        end
      end
      if (push)     r_sp <= w_sp_inc;
      else if (pop) r_sp <= w_sp_dec;
    end
  end

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_mux        = 2'b00;
    reg_write     = 1'b0;
    reg_write_mux = 2'b00;
    alu_in_mux    = 1'b0;
    reg_B_mux     = 1'b0;
    alu_use_carry = 1'b0;
    alu_op        = 3'b000;
    push          = 1'b0;
    pop           = 1'b0;
    halted        = 1'b0;
    stack_err     = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_arith) begin
          alu_op        = w_op[2:0];
          alu_use_carry = w_op[0];
          alu_in_mux    = w_op[3];
          w_next        = S_WB;
        end else if (w_is_shift) begin
          w_next = S_WB;
        end else if (w_is_mem) begin
          reg_B_mux  = 1'b1;
          alu_in_mux = 1'b1;
          w_next     = S_MEM;
        end else if (w_is_branch) begin
          pc_write = w_taken;
          pc_mux   = w_taken ? 2'b01 : 2'b00;
          w_next   = S_FETCH;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else if (w_stack_fault) begin
          w_next = S_FAULT;
        end else if (w_is_ret) begin
          pop      = 1'b1;
          pc_write = 1'b1;
          pc_mux   = 2'b11;
          w_next   = S_FETCH;
        end else begin
          pc_write = 1'b1;
          pc_mux   = 2'b10;
          push     = w_is_jsb;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write    = w_op[0];
        if (mem_ack) w_next = w_op[0] ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write     = 1'b1;
        reg_write_mux = w_is_arith ? 2'b00 : (w_is_shift ? 2'b01 : 2'b10);
        w_next        = S_FETCH;
      end
      S_HALT:   halted    = 1'b1;
      S_FAULT:  stack_err = 1'b1;
      default:  w_next    = S_IDLE;
    endcase
  end

endmodule
